// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: receiver state encoding and default bit timing at 48 MHz.
package ws2812_pkg;

  localparam int unsigned BITS_PER_LED = 24;

  // Nominal high times of the transmit side; the decode threshold sits midway.
  localparam int unsigned T0H_CYC    = 19;
  localparam int unsigned T1H_CYC    = 38;
  localparam int unsigned RESET_CYC  = 2400;
  localparam int unsigned DEF_THRESH = (T0H_CYC + T1H_CYC + 1) / 2;

  typedef enum logic [2:0] {
    RX_SYNC  = 3'd0,
    RX_READY = 3'd1,
    RX_HIGH  = 3'd2,
    RX_LOW   = 3'd3,
    RX_ERR   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Line conditioning for the WS2812 receiver: synchronizer, edge detect and
// high/low run-length counters with bit classification.
module ws2812_pulse_meas
  import ws2812_pkg::*;
#(
  parameter int unsigned MIN_HIGH     = 8,
  parameter int unsigned THRESH       = DEF_THRESH,
  parameter int unsigned MAX_HIGH     = 60,
  parameter int unsigned RESET_CYCLES = RESET_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  output logic o_rise_c,
  output logic o_bit_strobe_c,
  output logic o_bit_val_c,
  output logic o_glitch_c,
  output logic o_too_long_c,
  output logic o_gap_done_c
);

  localparam int unsigned HW = $clog2(MAX_HIGH + 2);
  localparam int unsigned LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] H_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] H_THR = HW'(THRESH);
  localparam logic [HW-1:0] H_MAX = HW'(MAX_HIGH);
  localparam logic [HW-1:0] H_SAT = HW'(MAX_HIGH + 1);
  localparam logic [LW-1:0] L_SAT = LW'(RESET_CYCLES);

  logic          r_sync1;
  logic          r_ds;
  logic          r_ds_q;
  logic [HW-1:0] r_hcnt;
  logic [LW-1:0] r_lcnt;
  logic          w_rise;
  logic          w_fall;

  assign w_rise = r_ds & ~r_ds_q;
  assign w_fall = ~r_ds & r_ds_q;

  // Each counter holds the length of the current run and clears on the
  // opposite level, so at a falling edge r_hcnt is exactly the pulse width.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_ds    <= 1'b0;
      r_ds_q  <= 1'b0;
      r_hcnt  <= '0;
      r_lcnt  <= '0;
    end else begin
      r_sync1 <= i_din;
      r_ds    <= r_sync1;
      r_ds_q  <= r_ds;
      if (r_ds) begin
        r_lcnt <= '0;
        if (r_hcnt != H_SAT) r_hcnt <= r_hcnt + HW'(1);
      end else begin
        r_hcnt <= '0;
        if (r_lcnt != L_SAT) r_lcnt <= r_lcnt + LW'(1);
      end
    end
  end

  assign o_rise_c       = w_rise;
  assign o_bit_strobe_c = w_fall && (r_hcnt >= H_MIN) && (r_hcnt <= H_MAX);
  assign o_bit_val_c    = (r_hcnt >= H_THR);
  assign o_glitch_c     = w_fall && (r_hcnt < H_MIN);
  assign o_too_long_c   = (r_hcnt > H_MAX);
  assign o_gap_done_c   = (r_lcnt == L_SAT);

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: decodes pulse widths into 24-bit pixel words and
// assembles them into a frame image that is published at the latch gap.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 48000000,
  parameter int unsigned MIN_HIGH     = 8,
  parameter int unsigned THRESH       = DEF_THRESH,
  parameter int unsigned MAX_HIGH     = 60,
  parameter int unsigned RESET_CYCLES = RESET_CYC,
  parameter int unsigned NUM_LEDS     = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             din,
  output logic                             word_valid,
  output logic [BITS_PER_LED-1:0]          word_data,
  output logic [$clog2(NUM_LEDS+1)-1:0]    word_idx,
  output logic                             frame_valid,
  output logic [NUM_LEDS*BITS_PER_LED-1:0] frame_data,
  output logic [$clog2(NUM_LEDS+1)-1:0]    frame_words,
  output logic                             err,
  output logic                             overflow
);

  localparam int unsigned IW = $clog2(NUM_LEDS + 1);
  localparam int unsigned BW = $clog2(BITS_PER_LED);

  localparam logic [IW-1:0] WCNT_SAT = IW'(NUM_LEDS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_LED - 1);

  localparam logic [2:0] S_SYNC  = RX_SYNC;
  localparam logic [2:0] S_READY = RX_READY;
  localparam logic [2:0] S_HIGH  = RX_HIGH;
  localparam logic [2:0] S_LOW   = RX_LOW;
  localparam logic [2:0] S_ERR   = RX_ERR;

  if (CLK_HZ == 0 || MIN_HIGH >= THRESH || THRESH > MAX_HIGH) begin : g_bad_timing
    $error("ws2812_rx: inconsistent pulse timing parameters");
  end

  logic [2:0]                               r_state;
  logic [BW-1:0]                            r_bit_cnt;
  logic [BITS_PER_LED-2:0]                  r_shift;
  logic [IW-1:0]                            r_word_cnt;
  logic [NUM_LEDS-1:0][BITS_PER_LED-1:0]    r_stage;

  logic          w_rise;
  logic          w_bit_strobe;
  logic          w_bit_val;
  logic          w_glitch;
  logic          w_too_long;
  logic          w_gap_done;
  logic [2:0]    w_state_nxt;
  logic          w_shift;
  logic          w_latch;
  logic          w_err_entry;
  logic          w_new_frame;
  logic          w_word_done;
  logic          w_store;
  logic [IW-1:0] w_slot;

  ws2812_pulse_meas #(
    .MIN_HIGH     (MIN_HIGH),
    .THRESH       (THRESH),
    .MAX_HIGH     (MAX_HIGH),
    .RESET_CYCLES (RESET_CYCLES)
  ) u_meas (
    .clk            (clk),
    .rst            (rst),
    .i_din          (din),
    .o_rise_c       (w_rise),
    .o_bit_strobe_c (w_bit_strobe),
    .o_bit_val_c    (w_bit_val),
    .o_glitch_c     (w_glitch),
    .o_too_long_c   (w_too_long),
    .o_gap_done_c   (w_gap_done)
  );

  // Next-state and control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_latch     = 1'b0;
    w_err_entry = 1'b0;
    w_new_frame = 1'b0;
    case (r_state)
      S_SYNC, S_ERR: begin
        if (w_gap_done) w_state_nxt = S_READY;
      end
      S_READY: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
          w_new_frame = 1'b1;
        end
      end
      S_HIGH: begin
        if (w_too_long || w_glitch) begin
          w_state_nxt = S_ERR;
          w_err_entry = 1'b1;
        end else if (w_bit_strobe) begin
          w_state_nxt = S_LOW;
          w_shift     = 1'b1;
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_state_nxt = S_HIGH;
        end else if (w_gap_done) begin
          w_state_nxt = S_READY;
          w_latch     = 1'b1;
        end
      end
      default: w_state_nxt = S_SYNC;
    endcase
  end

  assign w_word_done = w_shift && (r_bit_cnt == BIT_LAST);
  assign w_store     = w_word_done && (r_word_cnt != WCNT_SAT);
  // LED0 occupies the most significant slot of the frame image.
  assign w_slot      = WCNT_SAT - IW'(1) - r_word_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SYNC;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_word_cnt  <= '0;
      r_stage     <= '0;
      word_valid  <= 1'b0;
      word_data   <= '0;
      word_idx    <= '0;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      frame_words <= '0;
      err         <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      word_valid  <= w_word_done;
      frame_valid <= w_latch && (r_word_cnt != '0);
      err         <= w_err_entry || (w_latch && (r_bit_cnt != '0));

      if (w_shift) begin
        r_shift   <= {r_shift[BITS_PER_LED-3:0], w_bit_val};
        r_bit_cnt <= w_word_done ? '0 : r_bit_cnt + BW'(1);
      end

      if (w_word_done) begin
        word_data <= {r_shift, w_bit_val};
        word_idx  <= r_word_cnt;
        if (w_store) begin
          r_stage[w_slot] <= {r_shift, w_bit_val};
          r_word_cnt      <= r_word_cnt + IW'(1);
        end else begin
          overflow <= 1'b1;
        end
      end

      if (w_new_frame) overflow <= 1'b0;

      // A latch with no complete word leaves the published frame untouched.
      if (w_latch) begin
        if (r_word_cnt != '0) begin
          frame_data  <= r_stage;
          frame_words <= r_word_cnt;
        end
        r_stage    <= '0;
        r_word_cnt <= '0;
        r_bit_cnt  <= '0;
      end

      if (w_err_entry) begin
        r_stage    <= '0;
        r_word_cnt <= '0;
        r_bit_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx with a word/frame scoreboard fed by the stimulus.
module tb_ws2812_rx;

  localparam int unsigned NUM_LEDS = 6;
  localparam int unsigned IW       = $clog2(NUM_LEDS + 1);
  localparam int unsigned FW       = NUM_LEDS * 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          word_valid;
  logic [23:0]   word_data;
  logic [IW-1:0] word_idx;
  logic          frame_valid;
  logic [FW-1:0] frame_data;
  logic [IW-1:0] frame_words;
  logic          err;
  logic          overflow;

  always #5 clk = ~clk;

  ws2812_rx dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_idx    (word_idx),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_words (frame_words),
    .err         (err),
    .overflow    (overflow)
  );

  typedef struct {
    logic [IW-1:0] idx;
    logic [23:0]   data;
  } word_exp_t;

  typedef struct {
    logic [FW-1:0] data;
    logic [IW-1:0] words;
    logic          err;
  } frame_exp_t;

  word_exp_t   wq[$];
  frame_exp_t  fq[$];
  logic [23:0] m_words[$];
  logic [FW-1:0] last_frame = '0;

  int n_tests  = 0;
  int n_fail   = 0;
  int n_err    = 0;
  int n_words  = 0;
  int base_err = 0;
  int base_wds = 0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DUT word/frame must match the oldest pending expectation.
  always @(negedge clk) begin
    if (err) n_err++;
    if (word_valid) begin
      n_words++;
      if (wq.size() == 0) begin
        check("word_unexpected", FW'(word_valid), '0);
      end else begin
        word_exp_t e;
        e = wq.pop_front();
        check("word_idx", FW'(word_idx), FW'(e.idx));
        check("word_data", FW'(word_data), FW'(e.data));
      end
    end
    if (frame_valid) begin
      if (fq.size() == 0) begin
        check("frame_unexpected", FW'(frame_valid), '0);
      end else begin
        frame_exp_t f;
        f = fq.pop_front();
        check("frame_data", frame_data, f.data);
        check("frame_words", FW'(frame_words), FW'(f.words));
        check("frame_err", FW'(err), FW'(f.err));
        last_frame = f.data;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      din = 1'b1;
      cycles(v[i] ? 38 : 19);
      din = 1'b0;
      cycles(v[i] ? 22 : 41);
    end
  endtask

  task automatic expect_word(input logic [23:0] w);
    word_exp_t e;
    e.idx  = IW'(m_words.size() < NUM_LEDS ? m_words.size() : NUM_LEDS);
    e.data = w;
    wq.push_back(e);
    m_words.push_back(w);
  endtask

  task automatic tx_word(input logic [23:0] w, input bit decoded);
    if (decoded) expect_word(w);
    send_bits({8'h00, w}, 24);
  endtask

  // Drive the latch gap; a framed gap publishes the words collected so far.
  task automatic gap(input bit framed, input bit err_exp);
    if (framed) begin
      frame_exp_t f;
      int nw;
      f.data = '0;
      nw = (m_words.size() < NUM_LEDS) ? m_words.size() : NUM_LEDS;
      for (int i = 0; i < nw; i++) f.data[FW-1-24*i -: 24] = m_words[i];
      f.words = IW'(nw);
      f.err   = err_exp;
      fq.push_back(f);
    end
    m_words.delete();
    din = 1'b0;
    cycles(2500);
    check("words_pending", FW'(wq.size()), '0);
    check("frames_pending", FW'(fq.size()), '0);
  endtask

  task automatic mark();
    base_err = n_err;
    base_wds = n_words;
  endtask

  task automatic check_counts(input string tag, input int exp_words, input int exp_errs);
    check({tag, "_word_count"}, FW'(n_words - base_wds), FW'(exp_words));
    check({tag, "_err_count"}, FW'(n_err - base_err), FW'(exp_errs));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, FW'({word_valid, frame_valid, err, overflow}), '0);
    check({tag, "_word"}, FW'({word_idx, word_data}), '0);
    check({tag, "_frame_data"}, frame_data, '0);
    check({tag, "_frame_words"}, FW'(frame_words), '0);
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    cycles(3);
    check_all_zero("reset");
    rst = 1'b0;

    // Clean six-word frame after a leading latch gap.
    mark();
    cycles(2450);
    tx_word(24'hFF0000, 1'b1);
    tx_word(24'h00FF00, 1'b1);
    tx_word(24'h0000FF, 1'b1);
    tx_word(24'hA5A5A5, 1'b1);
    tx_word(24'h000001, 1'b1);
    tx_word(24'h800000, 1'b1);
    check("t1_overflow", FW'(overflow), '0);
    gap(1'b1, 1'b0);
    check_counts("t1", 6, 0);

    // Traffic straight after reset is ignored until the line idles.
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    mark();
    tx_word(24'h123456, 1'b0);
    tx_word(24'h654321, 1'b0);
    gap(1'b0, 1'b0);
    check_counts("t2_nosync", 0, 0);
    tx_word(24'h0F0F0F, 1'b1);
    gap(1'b1, 1'b0);
    check_counts("t2", 1, 0);

    // Short glitch mid-word: one error, old frame kept, clean recovery.
    mark();
    send_bits(32'h000002AB, 10);
    din = 1'b1;
    cycles(5);
    din = 1'b0;
    cycles(40);
    gap(1'b0, 1'b0);
    check_counts("t3_glitch", 0, 1);
    check("t3_frame_kept", frame_data, last_frame);
    tx_word(24'h5A5A5A, 1'b1);
    gap(1'b1, 1'b0);
    check_counts("t3", 1, 1);

    // Seven words: last one dropped, overflow sticky until the next frame.
    mark();
    for (int i = 0; i < 6; i++) tx_word(24'h111111 * 24'(i + 1), 1'b1);
    check("t4_no_overflow_yet", FW'(overflow), '0);
    tx_word(24'hDEAD77, 1'b1);
    check("t4_overflow_set", FW'(overflow), FW'(1));
    gap(1'b1, 1'b0);
    check("t4_overflow_held", FW'(overflow), FW'(1));
    expect_word(24'h800001);
    din = 1'b1;
    cycles(6);
    check("t4_overflow_cleared", FW'(overflow), '0);
    cycles(32);
    din = 1'b0;
    cycles(22);
    send_bits(32'h00000001, 23);
    gap(1'b1, 1'b0);
    check_counts("t4", 8, 0);

    // 30 bits: one word plus a partial tail that flags err at the latch.
    mark();
    tx_word(24'h3C5A96, 1'b1);
    send_bits(32'h0000002D, 6);
    gap(1'b1, 1'b1);
    check_counts("t5", 1, 1);

    // Reset in the middle of bit 12 clears everything and forces resync.
    mark();
    send_bits(32'h00000ABC, 11);
    din = 1'b1;
    cycles(10);
    rst = 1'b1;
    cycles(1);
    check_all_zero("t6_rst");
    rst = 1'b0;
    cycles(28);
    din = 1'b0;
    cycles(22);
    send_bits(32'h000007FF, 11);
    tx_word(24'hC0FFEE, 1'b0);
    gap(1'b0, 1'b0);
    check_counts("t6_ignored", 0, 0);
    tx_word(24'h0BEEF0, 1'b1);
    gap(1'b1, 1'b0);
    check_counts("t6", 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
